// File: rtl/kb_event_sequencer.sv
// Keyboard event sequencer: turns PS/2 scancode bytes into make/break events,
// queues them and serves them to the PicoBlaze through port_id-addressed reads.
module kb_event_sequencer #(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] TIMEOUT     = 16'd50000,
  parameter logic [7:0]  PORT_STATUS = 8'h10,
  parameter logic [7:0]  PORT_CODE   = 8'h11,
  parameter logic [7:0]  PORT_FLAGS  = 8'h12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] data_out,
  output logic       kb_irq
);

  localparam int         PW      = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_E0   = 2'd1;
  localparam logic [1:0] ST_F0   = 2'd2;
  localparam logic [1:0] ST_E0F0 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [7:0]    code_mem_q [DEPTH];
  logic [1:0]    flag_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [7:0]    data_out_q, data_d;
  logic          kb_irq_q;

  logic       is_e0_s, is_f0_s;
  logic       push_s, perr_s, pop_s, push_ok_s;
  logic       full_s, empty_s, status_rd_s;
  logic [1:0] push_flags_s;
  logic [7:0] status_s;

  assign is_e0_s     = (scan_code == 8'hE0);
  assign is_f0_s     = (scan_code == 8'hF0);
  assign empty_s     = (count_q == 3'd0);
  assign full_s      = (count_q == DEPTH_C);
  assign pop_s       = read_strobe && (port_id == PORT_FLAGS) && !empty_s;
  assign push_ok_s   = push_s && (!full_s || pop_s);
  assign status_rd_s = read_strobe && (port_id == PORT_STATUS);
  assign count_d     = count_q + {2'b00, push_ok_s} - {2'b00, pop_s};
  assign status_s    = {1'b0, count_q, err_q, ovf_q, full_s, !empty_s};
  assign data_out    = data_out_q;
  assign kb_irq      = kb_irq_q;

  // Prefix parser and abandon timer; a received byte always beats the timeout.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    push_s       = 1'b0;
    push_flags_s = 2'b00;
    perr_s       = 1'b0;
    if (scan_valid) begin
      tmo_d = 16'd0;
      case (state_q)
        ST_IDLE: begin
          if (is_e0_s) begin
            state_d = ST_E0;
          end else if (is_f0_s) begin
            state_d = ST_F0;
          end else begin
            push_s = 1'b1;
          end
        end
        ST_E0: begin
          if (is_f0_s) begin
            state_d = ST_E0F0;
          end else if (is_e0_s) begin
            perr_s = 1'b1;
          end else begin
            push_s       = 1'b1;
            push_flags_s = 2'b10;
            state_d      = ST_IDLE;
          end
        end
        ST_F0: begin
          if (is_e0_s) begin
            perr_s  = 1'b1;
            state_d = ST_E0;
          end else if (is_f0_s) begin
            perr_s = 1'b1;
          end else begin
            push_s       = 1'b1;
            push_flags_s = 2'b01;
            state_d      = ST_IDLE;
          end
        end
        ST_E0F0: begin
          if (is_e0_s) begin
            perr_s  = 1'b1;
            state_d = ST_E0;
          end else if (is_f0_s) begin
            perr_s  = 1'b1;
            state_d = ST_F0;
          end else begin
            push_s       = 1'b1;
            push_flags_s = 2'b11;
            state_d      = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = 16'd0;
    end else if (tmo_q == (TIMEOUT - 16'd1)) begin
      tmo_d   = 16'd0;
      state_d = ST_IDLE;
      perr_s  = 1'b1;
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  // Sticky overflow/error flags: a set in the same cycle as a status read wins.
  always_comb begin
    if (push_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else if (status_rd_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (perr_s) begin
      err_d = 1'b1;
    end else if (status_rd_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Read-data mux; code/flags read as zero while the queue is empty.
  always_comb begin
    data_d = 8'h00;
    case (port_id)
      PORT_STATUS: data_d = status_s;
      PORT_CODE:   data_d = empty_s ? 8'h00 : code_mem_q[rd_ptr_q];
      PORT_FLAGS:  data_d = empty_s ? 8'h00 : {6'b000000, flag_mem_q[rd_ptr_q]};
      default:     data_d = 8'h00;
    endcase
  end

  // State, queue storage and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      tmo_q      <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 3'd0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= 8'h00;
      kb_irq_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        code_mem_q[i] <= 8'h00;
        flag_mem_q[i] <= 2'b00;
      end
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      data_out_q <= data_d;
      kb_irq_q   <= !empty_s;
      if (push_ok_s) begin
        code_mem_q[wr_ptr_q] <= scan_code;
        flag_mem_q[wr_ptr_q] <= push_flags_s;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_kb_event_sequencer.sv
// Scoreboard bench for kb_event_sequencer: expected events are queued as
// scancodes are driven and compared as the processor-side reads pop them.
module tb_kb_event_sequencer;

  localparam logic [15:0] TP = 16'd40;
  localparam logic [7:0]  PS = 8'h10;
  localparam logic [7:0]  PC = 8'h11;
  localparam logic [7:0]  PF = 8'h12;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic [7:0] data_out;
  logic       kb_irq;

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_q[$];

  kb_event_sequencer #(
    .DEPTH(4), .TIMEOUT(TP), .PORT_STATUS(PS), .PORT_CODE(PC), .PORT_FLAGS(PF)
  ) dut (
    .CLK(CLK), .RESET(RESET), .scan_valid(scan_valid), .scan_code(scan_code),
    .port_id(port_id), .read_strobe(read_strobe), .data_out(data_out), .kb_irq(kb_irq)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic read_port(input logic [7:0] pid, input logic strb, output logic [7:0] d);
    port_id = pid;
    tick();
    d = data_out;
    if (strb) begin
      read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0;
    end
    port_id = 8'h00;
  endtask

  task automatic pop_event(output logic [15:0] got);
    logic [7:0] c, f;
    read_port(PC, 1'b0, c);
    read_port(PF, 1'b1, f);
    got = {c, f};
  endtask

  task automatic next_exp(output logic [15:0] e);
    if (exp_q.size() == 0) e = 16'hXXXX;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RESET = 1'b1;
    repeat (3) tick();
    nvec++;
    if (data_out !== 8'h00 || kb_irq !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs: data_out=%h kb_irq=%b, expected 00/0", data_out, kb_irq);
    end
    RESET = 1'b0;
    tick();
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h00) begin nerr++; $display("FAIL reset_status: got %h, expected 00", d); end
  endtask

  task automatic test_make_break();
    logic [7:0] d;
    logic [15:0] got, e;
    send_byte(8'h1C); exp_q.push_back({8'h1C, 8'h00});
    nvec++;
    if (kb_irq !== 1'b0) begin nerr++; $display("FAIL irq_lag: got %b, expected 0", kb_irq); end
    tick();
    nvec++;
    if (kb_irq !== 1'b1) begin nerr++; $display("FAIL irq_rise: got %b, expected 1", kb_irq); end
    send_byte(8'hF0);
    send_byte(8'h1C); exp_q.push_back({8'h1C, 8'h01});
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h21) begin nerr++; $display("FAIL mb_status: got %h, expected 21", d); end
    for (int i = 0; i < 2; i++) begin
      pop_event(got); next_exp(e);
      nvec++;
      if (got !== e) begin nerr++; $display("FAIL mb_event: got %h, expected %h", got, e); end
    end
  endtask

  task automatic test_extended();
    logic [7:0] d;
    logic [15:0] got, e;
    send_byte(8'hE0);
    send_byte(8'h75); exp_q.push_back({8'h75, 8'h02});
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75); exp_q.push_back({8'h75, 8'h03});
    for (int i = 0; i < 2; i++) begin
      pop_event(got); next_exp(e);
      nvec++;
      if (got !== e) begin nerr++; $display("FAIL ext_event: got %h, expected %h", got, e); end
    end
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h00 || kb_irq !== 1'b0) begin
      nerr++;
      $display("FAIL ext_drained: status=%h kb_irq=%b, expected 00/0", d, kb_irq);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [15:0] got, e;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h11 + 8'(i));
      if (i < 4) exp_q.push_back({8'h11 + 8'(i), 8'h00});
    end
    read_port(PS, 1'b1, d);
    nvec++;
    if (d !== 8'h47) begin nerr++; $display("FAIL ovf_status: got %h, expected 47", d); end
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h43) begin nerr++; $display("FAIL ovf_cleared: got %h, expected 43", d); end
    for (int i = 0; i < 4; i++) begin
      pop_event(got); next_exp(e);
      nvec++;
      if (got !== e) begin nerr++; $display("FAIL ovf_event: got %h, expected %h", got, e); end
    end
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h00) begin nerr++; $display("FAIL ovf_fifth_lost: status %h, expected 00", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, f;
    logic [15:0] got, e;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h21 + 8'(i));
      exp_q.push_back({8'h21 + 8'(i), 8'h00});
    end
    port_id = PF;
    tick();
    f = data_out;
    scan_valid  = 1'b1;
    scan_code   = 8'h25;
    read_strobe = 1'b1;
    tick();
    scan_valid  = 1'b0;
    read_strobe = 1'b0;
    port_id     = 8'h00;
    next_exp(e);
    exp_q.push_back({8'h25, 8'h00});
    nvec++;
    if (f !== e[7:0]) begin nerr++; $display("FAIL b2b_head_flags: got %h, expected %h", f, e[7:0]); end
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h43) begin nerr++; $display("FAIL b2b_status: got %h, expected 43", d); end
    for (int i = 0; i < 4; i++) begin
      pop_event(got); next_exp(e);
      nvec++;
      if (got !== e) begin nerr++; $display("FAIL b2b_event: got %h, expected %h", got, e); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    logic [15:0] got, e;
    send_byte(8'hF0);
    repeat (int'(TP) - 1) tick();
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h00) begin nerr++; $display("FAIL tmo_early: got %h, expected 00", d); end
    read_port(PS, 1'b1, d);
    nvec++;
    if (d !== 8'h08) begin nerr++; $display("FAIL tmo_err: got %h, expected 08", d); end
    send_byte(8'h1C); exp_q.push_back({8'h1C, 8'h00});
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h11) begin nerr++; $display("FAIL tmo_after: got %h, expected 11", d); end
    pop_event(got); next_exp(e);
    nvec++;
    if (got !== e) begin nerr++; $display("FAIL tmo_event: got %h, expected %h", got, e); end
  endtask

  task automatic test_err_reset();
    logic [7:0] d;
    logic [15:0] got, e;
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h6B); exp_q.push_back({8'h6B, 8'h02});
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h19) begin nerr++; $display("FAIL err_status: got %h, expected 19", d); end
    pop_event(got); next_exp(e);
    nvec++;
    if (got !== e) begin nerr++; $display("FAIL err_event: got %h, expected %h", got, e); end
    send_byte(8'h31);
    send_byte(8'h32);
    port_id = PS;
    tick();
    nvec++;
    if (data_out !== 8'h29 || kb_irq !== 1'b1) begin
      nerr++;
      $display("FAIL prereset: data_out=%h kb_irq=%b, expected 29/1", data_out, kb_irq);
    end
    #2 RESET = 1'b1;
    #1;
    nvec++;
    if (data_out !== 8'h00 || kb_irq !== 1'b0) begin
      nerr++;
      $display("FAIL midreset: data_out=%h kb_irq=%b, expected 00/0", data_out, kb_irq);
    end
    tick();
    RESET = 1'b0;
    read_port(PS, 1'b0, d);
    nvec++;
    if (d !== 8'h00) begin nerr++; $display("FAIL postreset_status: got %h, expected 00", d); end
    pop_event(got);
    nvec++;
    if (got !== 16'h0000) begin nerr++; $display("FAIL postreset_empty: got %h, expected 0000", got); end
    nvec++;
    if (exp_q.size() != 0) begin nerr++; $display("FAIL scoreboard_left: %0d entries, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/kb_event_sequencer.md
Name: kb_event_sequencer

Overview:
- Sits between the PS/2 byte receiver and the PicoBlaze input port.
- Parses raw scancode bytes (E0 extended prefix, F0 break prefix) into key events and queues them in a small FIFO.
- Serves the events to the processor through port_id-addressed reads: status, code, and flags, where reading flags pops the event.
- Raises a level interrupt request while events are pending.

Parameters:
- DEPTH, 4, event FIFO depth; power of two, 2 or 4.
- TIMEOUT, 16'd50000, CLK cycles a prefix may wait for its next byte before being abandoned.
- PORT_STATUS, 8'h10, port_id of the status register.
- PORT_CODE, 8'h11, port_id of the head event code (no side effect).
- PORT_FLAGS, 8'h12, port_id of the head event flags; a read pops the head.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- scan_valid  in  1  one-cycle pulse: scan_code holds a new received byte.
- scan_code  in  8  received PS/2 byte.
- port_id  in  8  PicoBlaze port address.
- read_strobe  in  1  PicoBlaze read strobe, one cycle.
- data_out  out  8  registered read data for the PicoBlaze in_port mux.
- kb_irq  out  1  registered; high while the FIFO is non-empty.

Behaviour:
- Reset (asynchronous): parser in IDLE, FIFO empty, pointers and count 0, overflow=0, err=0, timeout counter 0, data_out=8'h00, kb_irq=0.
- Event format: code[7:0] plus flags[7:0]; flags bit0=break, bit1=extended, bits7:2=0.
- Parser FSM (advances only on scan_valid):
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; any other byte -> push {flags 00, code}, stay in IDLE.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> stay, set err; other -> push {flags 02, code} -> IDLE.
  - GOT_F0: E0 -> set err, GOT_E0; F0 -> stay, set err; other -> push {flags 01, code} -> IDLE.
  - GOT_E0F0: E0 or F0 -> set err, treat as fresh prefix (E0 -> GOT_E0, F0 -> GOT_F0); other -> push {flags 03, code} -> IDLE.
- Timeout:
  - Counter clears on every scan_valid and while in IDLE; otherwise increments.
  - On reaching TIMEOUT-1 in any prefix state: next state IDLE, err set, nothing pushed.
  - A scan_valid in the same cycle takes priority over the timeout.
- Push: the event is written at the end of the cycle in which scan_valid is processed.
  - FIFO full with no pop in the same cycle: event dropped, overflow set.
- Pop: read_strobe=1 with port_id==PORT_FLAGS and FIFO non-empty.
  - Empty FIFO: pop ignored, no flag change.
- Simultaneous push and pop: both occur and count is unchanged; legal when full (pop frees the slot, no overflow) and when empty (no pop, push accepted).
- Status byte: bit0=non-empty, bit1=full, bit2=overflow, bit3=err, bits6:4=count (0..DEPTH), bit7=0.
- Status read (read_strobe with port_id==PORT_STATUS): clears overflow and err after the cycle. If a set event occurs in the same cycle, set wins.
- data_out: registered every cycle from the current port_id, so it is valid 1 cycle after port_id changes.
  - PORT_STATUS -> status; PORT_CODE -> head code; PORT_FLAGS -> head flags.
  - Empty FIFO on code/flags ports -> 8'h00; any unmatched port_id -> 8'h00.
  - PicoBlaze holds port_id for 2 cycles, so data_out is stable when read_strobe samples.
- kb_irq: registered (count != 0); deasserts 1 cycle after the pop that empties the FIFO.
- RESET mid-frame: pending prefix and all queued events are discarded.

Test Plan:
- Reset, then bytes 1C, F0, 1C: two events, {code 1C, flags 00} and {1C, 01}; status=8'h21; kb_irq high 1 cycle after first push.
- Bytes E0, 75, E0, F0, 75: events {75, 02} and {75, 03}; read CODE then FLAGS twice -> 75/02, 75/03; status then 8'h00; kb_irq low.
- Push 5 events with DEPTH=4: status=8'h47 (count 4, full, overflow, non-empty); next status read clears bit2 -> 8'h43; the 5th event is lost.
- FIFO full, scan_valid and a FLAGS read in the same cycle: count stays 4, overflow stays 0, new event lands at the tail.
- Byte F0, then idle TIMEOUT cycles: parser returns to IDLE, err=1 (status 8'h08), no event; next byte 1C -> {1C, 00}.
- F0, E0, 6B: err set, event {6B, 02}. Assert RESET with 2 events queued -> status 8'h00, data_out 8'h00, kb_irq 0.
